// File: rtl/disp_pkg.sv
// Shared types and default constants for the display scheduler block.
package disp_pkg;

    typedef enum logic [1:0] {
        BG      = 2'd0,
        MSG_ON  = 2'd1,
        MSG_OFF = 2'd2
    } disp_state_t;

    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_SCAN_HZ     = 200;
    localparam int DEF_MSG_TICKS   = 400;
    localparam int DEF_BLINK_TICKS = 50;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle registered tick every DIV clocks.
module tick_prescaler
    import disp_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            W    = cnt_width(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == LAST);
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Chooses between the background value and a timed, optionally blinking
// message for a 4-digit display, and generates the digit-scan tick.
module display_scheduler
    import disp_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int SCAN_HZ     = DEF_SCAN_HZ,
    parameter int MSG_TICKS   = DEF_MSG_TICKS,
    parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bg_value,
    input  logic [15:0] msg_value,
    input  logic        msg_blink,
    input  logic        msg_req,
    output logic        msg_ack,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic        scan_tick,
    output logic        busy
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int HW  = cnt_width(MSG_TICKS);
    localparam int BW  = cnt_width(BLINK_TICKS);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(MSG_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    disp_state_t   state;
    logic [15:0]   msg_lat;
    logic          blink_lat;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (scan_tick)
    );

    // A new request always wins: it pre-empts an active message and beats a
    // same-cycle expiry. Expiry in turn beats a blink toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BG;
            msg_lat   <= '0;
            blink_lat <= 1'b0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            value     <= '0;
            blank     <= 4'b0000;
            busy      <= 1'b0;
            msg_ack   <= 1'b0;
        end else begin
            msg_ack <= 1'b0;
            if (msg_req) begin
                state     <= MSG_ON;
                msg_lat   <= msg_value;
                blink_lat <= msg_blink;
                hold_cnt  <= '0;
                blink_cnt <= '0;
                value     <= msg_value;
                blank     <= 4'b0000;
                busy      <= 1'b1;
                msg_ack   <= 1'b1;
            end else begin
                case (state)
                    BG: begin
                        value <= bg_value;
                        blank <= 4'b0000;
                        busy  <= 1'b0;
                    end
                    MSG_ON, MSG_OFF: begin
                        value <= msg_lat;
                        if (scan_tick) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state     <= BG;
                                hold_cnt  <= '0;
                                blink_cnt <= '0;
                                value     <= bg_value;
                                blank     <= 4'b0000;
                                busy      <= 1'b0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                                if (blink_lat) begin
                                    if (blink_cnt == BLINK_LAST) begin
                                        blink_cnt <= '0;
                                        if (state == MSG_ON) begin
                                            state <= MSG_OFF;
                                            blank <= 4'b1111;
                                        end else begin
                                            state <= MSG_ON;
                                            blank <= 4'b0000;
                                        end
                                    end else begin
                                        blink_cnt <= blink_cnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state <= BG;
                        value <= bg_value;
                        blank <= 4'b0000;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench: DIV=10, MSG_TICKS=4, BLINK_TICKS=1; outputs sampled 1ns after each rising edge.
module tb_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bg_value;
    logic [15:0] msg_value;
    logic        msg_blink;
    logic        msg_req;
    logic        msg_ack;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        scan_tick;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    display_scheduler #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .MSG_TICKS   (4),
        .BLINK_TICKS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bg_value  (bg_value),
        .msg_value (msg_value),
        .msg_blink (msg_blink),
        .msg_req   (msg_req),
        .msg_ack   (msg_ack),
        .value     (value),
        .blank     (blank),
        .scan_tick (scan_tick),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until scan_tick is seen high; returns the number of cycles taken.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (scan_tick !== 1'b1 && cycles < 40);
        check("tick_seen", {31'd0, scan_tick}, 32'd1);
    endtask

    task automatic send_msg(input logic [15:0] v, input logic b);
        msg_value = v;
        msg_blink = b;
        msg_req   = 1'b1;
        step();
        msg_req   = 1'b0;
        check("msg_ack", {31'd0, msg_ack}, 32'd1);
        check("msg_value", {16'd0, value}, {16'd0, v});
        check("msg_busy", {31'd0, busy}, 32'd1);
    endtask

    logic [3:0] blink_exp [4] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};

    initial begin
        rst       = 1'b1;
        bg_value  = 16'h1234;
        msg_value = 16'h0000;
        msg_blink = 1'b0;
        msg_req   = 1'b0;
        step();
        step();
        check("rst_value", {16'd0, value}, 32'h0);
        check("rst_blank", {28'd0, blank}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, msg_ack}, 32'd0);
        check("rst_tick", {31'd0, scan_tick}, 32'd0);

        // Background follows bg_value one cycle after release.
        rst = 1'b0;
        step();
        check("bg_value", {16'd0, value}, 32'h1234);
        check("bg_blank", {28'd0, blank}, 32'h0);
        wait_tick(n);
        check("first_tick_gap", n, 9);
        wait_tick(n);
        check("tick_period", n, 10);
        step();
        check("tick_one_cycle", {31'd0, scan_tick}, 32'd0);

        // Steady message, no blink: back to background on the 4th tick.
        send_msg(16'h00AB, 1'b0);
        check("msg_blank", {28'd0, blank}, 32'h0);
        step();
        check("ack_pulse", {31'd0, msg_ack}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            step();
            check("steady_busy", {31'd0, busy}, 32'd1);
            check("steady_value", {16'd0, value}, 32'h00AB);
        end
        wait_tick(n);
        step();
        check("expire_value", {16'd0, value}, 32'h1234);
        check("expire_busy", {31'd0, busy}, 32'd0);
        check("expire_blank", {28'd0, blank}, 32'h0);

        // Blinking message: toggle every tick, expiry wins on the 4th.
        send_msg(16'h00CD, 1'b1);
        check("blink_start_blank", {28'd0, blank}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            step();
            check("blink_blank", {28'd0, blank}, {28'd0, blink_exp[k]});
            check("blink_busy", {31'd0, busy}, (k == 3) ? 32'd0 : 32'd1);
        end
        check("blink_end_value", {16'd0, value}, 32'h1234);

        // Pre-emption two ticks in restarts a full 4-tick hold.
        send_msg(16'h00AB, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_tick(n);
            step();
        end
        send_msg(16'h0055, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            step();
            check("preempt_busy", {31'd0, busy}, 32'd1);
            check("preempt_value", {16'd0, value}, 32'h0055);
        end
        wait_tick(n);
        step();
        check("preempt_expire_busy", {31'd0, busy}, 32'd0);
        check("preempt_expire_value", {16'd0, value}, 32'h1234);

        // Request on the expiry edge wins: no background cycle.
        send_msg(16'h0011, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            step();
        end
        wait_tick(n);
        send_msg(16'h0077, 1'b0);
        step();
        check("collide_busy", {31'd0, busy}, 32'd1);
        check("collide_value", {16'd0, value}, 32'h0077);

        // Reset during MSG_OFF clears outputs without a clock edge.
        send_msg(16'h0099, 1'b1);
        wait_tick(n);
        step();
        check("off_blank", {28'd0, blank}, 32'hF);
        rst = 1'b1;
        #1;
        check("arst_value", {16'd0, value}, 32'h0);
        check("arst_blank", {28'd0, blank}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ack", {31'd0, msg_ack}, 32'd0);
        step();
        step();
        check("arst_ack_held", {31'd0, msg_ack}, 32'd0);
        rst = 1'b0;
        step();
        check("rel_value", {16'd0, value}, 32'h1234);
        check("rel_ack", {31'd0, msg_ack}, 32'd0);
        wait_tick(n);
        check("rel_tick_gap", n, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter SCAN_HZ, default 200, digit-scan tick rate in Hz.
REQ-003 The block SHALL have parameter MSG_TICKS, default 400, message hold time in scan ticks; legal range is 1 or greater.
REQ-004 The block SHALL have parameter BLINK_TICKS, default 50, message blink half-period in scan ticks; legal range is 1 or greater.
REQ-005 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous reset, active high.
REQ-008 The block SHALL have port bg_value, input, 16 bits: background display value, 4 nibbles.
REQ-009 The block SHALL have port msg_value, input, 16 bits: message value, sampled on acceptance.
REQ-010 The block SHALL have port msg_blink, input, 1 bit: blink enable, sampled with msg_value.
REQ-011 The block SHALL have port msg_req, input, 1 bit: message request, level.
REQ-012 The block SHALL have port msg_ack, output, 1 bit: one-cycle pulse on message acceptance.
REQ-013 The block SHALL have port value, output, 16 bits: registered value for the segment driver.
REQ-014 The block SHALL have port blank, output, 4 bits: registered per-digit blanking mask, where 1 means the digit is off.
REQ-015 The block SHALL have port scan_tick, output, 1 bit: one-cycle pulse at SCAN_HZ that steps the digit mux.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a message owns the display.

Function
REQ-017 The prescaler SHALL count 0 to DIV-1 with DIV = CLK_HZ/SCAN_HZ (integer) and pulse scan_tick for exactly one cycle when count equals DIV-1, then wrap to 0.
REQ-018 The FSM SHALL have states BG, MSG_ON and MSG_OFF.
REQ-019 In BG, value SHALL equal bg_value and blank SHALL equal 4'b0000, both registered with 1-cycle latency.
REQ-020 When msg_req is sampled high in any state, the block SHALL latch msg_value and msg_blink, pulse msg_ack on the next cycle, clear the hold and blink counters, and enter MSG_ON.
REQ-021 A request arriving while a message is active SHALL pre-empt it and restart the hold time.
REQ-022 The requester SHALL drop msg_req after msg_ack; a request held high SHALL be re-accepted each cycle, which is legal but restarts the hold time.
REQ-023 In MSG_ON, value SHALL be the latched message and blank SHALL be 4'b0000; in MSG_OFF, value SHALL be the latched message and blank SHALL be 4'b1111.
REQ-024 The hold counter SHALL increment on each scan_tick in MSG_ON or MSG_OFF; on the scan_tick where it equals MSG_TICKS-1, the FSM SHALL enter BG.
REQ-025 If the latched blink is 1, the blink counter SHALL increment on each scan_tick and, on reaching BLINK_TICKS-1, clear and toggle MSG_ON/MSG_OFF.
REQ-026 If the latched blink is 0, the FSM SHALL stay in MSG_ON until expiry.
REQ-027 If expiry and a blink toggle occur on the same tick, expiry SHALL win and the FSM SHALL enter BG.
REQ-028 If msg_req and expiry occur in the same cycle, the request SHALL win, producing a new message and msg_ack.
REQ-029 busy SHALL be high in MSG_ON and MSG_OFF and low in BG, registered with the state.
REQ-030 Counter widths SHALL be sized from the parameters and SHALL not overflow for legal values.

Reset
REQ-031 On rst high, asynchronously: state SHALL be BG, prescaler and counters 0, value 16'h0000, blank 4'b0000, msg_ack 0, scan_tick 0, busy 0, latched message 0.
REQ-032 Reset asserted mid-message SHALL abort the message with no msg_ack; after release, the first scan_tick SHALL occur DIV cycles later.

Structure
REQ-033 A shared package disp_pkg SHALL hold the FSM state type (BG, MSG_ON, MSG_OFF) and the default CLK_HZ, SCAN_HZ, MSG_TICKS and BLINK_TICKS constants.
REQ-034 The prescaler SHALL be a sub-module named tick_prescaler, with parameter DIV and ports clk, rst and tick.

Verification (CLK_HZ=1000, SCAN_HZ=100, so DIV=10; MSG_TICKS=4; BLINK_TICKS=1)
REQ-035 The bench SHALL check that, after reset release with bg_value=16'h1234, value=16'h1234 and blank=0 one cycle later, and that scan_tick pulses every 10 cycles.
REQ-036 The bench SHALL check that msg_req for 1 cycle with msg_value=16'h00AB and blink=0 gives msg_ack 1 cycle later, busy=1 and value=16'h00AB, with return to 16'h1234 on the 4th scan_tick.
REQ-037 The bench SHALL check that blink=1 gives blank alternating 1111/0000 on every scan_tick, then BG on the 4th tick with blank=0000.
REQ-038 The bench SHALL check that a second msg_req (16'h0055) asserted 2 ticks into a message is acknowledged, value becomes 16'h0055, and the hold restarts for a full 4 ticks.
REQ-039 The bench SHALL check that msg_req in the expiry cycle gives msg_ack, with busy staying high and no BG cycle.
REQ-040 The bench SHALL check that rst asserted during MSG_OFF immediately gives value=0, blank=0, busy=0 and no msg_ack.
